prime_check: RTL and testbench
==============================

PRIME_CHECK -- requirements
Module: prime_check

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the bit width of the candidate and of the modulo datapath.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port go  input  1  start request; only a 0->1 edge, sampled against a registered copy of go, starts a test.
REQ-005 SHALL have port n  input  WIDTH  candidate, sampled on the go edge.
REQ-006 SHALL have port ready  output  1  high when idle and the result outputs are valid.
REQ-007 SHALL have port is_prime  output  1  result of the last completed test.
REQ-008 SHALL have port error  output  1  last test aborted on a modulo-unit error.
REQ-009 SHALL have port ops  output  WIDTH  number of modulo operations issued in the last or current test.
REQ-010 SHALL have ports mod_go (output, 1), mod_a (output, WIDTH) and mod_b (output, WIDTH) driving the modulo unit.
REQ-011 SHALL have ports mod_ready (input, 1), mod_error (input, 1) and mod_res (input, WIDTH) from the modulo unit.

Function
REQ-012 SHALL implement FSM states IDLE, CHECK, ISSUE and WAIT.
REQ-013 IDLE: on a go edge, latch n, set d=2, sq=4, ops=0, drop ready, and go to CHECK next cycle.
REQ-014 IDLE: a go level with no edge SHALL NOT start a test.
REQ-015 While not IDLE, go edges SHALL be ignored and SHALL NOT restart or queue a test.
REQ-016 CHECK: if n<2, set is_prime=0 and go to IDLE.
REQ-017 CHECK: else if sq>n, set is_prime=1 and go to IDLE.
REQ-018 CHECK: else go to ISSUE.
REQ-019 sq SHALL be 2*WIDTH bits wide, so it cannot overflow.
REQ-020 ISSUE: drive mod_go=1 for exactly one cycle with mod_a=n and mod_b=d, increment ops, and go to WAIT.
REQ-021 mod_go SHALL be 0 in every other state, guaranteeing a fresh edge per operation.
REQ-022 mod_a/mod_b SHALL hold their values until the next ISSUE.
REQ-023 WAIT: mod_ready SHALL be ignored in the first WAIT cycle.
REQ-024 WAIT: from the second WAIT cycle on, stay in WAIT while mod_ready=0.
REQ-025 WAIT, on mod_ready=1 with mod_error=1: set error=1, is_prime=0, go to IDLE.
REQ-026 WAIT, on mod_ready=1 with mod_res=0: set is_prime=0 (composite), go to IDLE.
REQ-027 WAIT, on mod_ready=1 otherwise: advance the divisor and go to CHECK.
REQ-028 Divisor advance: if d==2 then d=3, sq=9; else sq=sq+4d+4, d=d+2, i.e. divisors 2, then odd values only.
REQ-029 ready SHALL be registered, rising in the same cycle the FSM enters IDLE.
REQ-030 is_prime and error SHALL change only on test completion.
REQ-031 error SHALL be cleared to 0 when a new test starts.
REQ-032 ops SHALL saturate at all-ones rather than wrap.
REQ-033 Boundary n=0/1: result not prime, ops=0.
REQ-034 Boundary n=2/3: result prime, ops=0.
REQ-035 Boundary n=4: result composite, ops=1.

Reset
REQ-036 On rst=1 at a clock edge, regardless of state (including mid-test), the FSM SHALL enter IDLE.
REQ-037 On reset: ready=1, is_prime=0, error=0, ops=0, mod_go=0, mod_a=0, mod_b=0, and the registered go copy=0.
REQ-038 An in-flight modulo result SHALL be discarded on reset.
REQ-039 If go is already high when rst deasserts, that SHALL count as an edge and start a test.

Verification
REQ-040 n=97, go pulse -> ready low, then high with is_prime=1, error=0, ops=5 (divisors 2,3,5,7,9).
REQ-041 n=91 -> is_prime=0, ops=4 (stops at divisor 7); n=4 -> is_prime=0, ops=1.
REQ-042 n=0, 1, 2, 3 each -> ops=0; is_prime=0, 0, 1, 1; ready back high within 3 cycles of the go edge.
REQ-043 n=65521 -> is_prime=1, ops=128 (2 and odd 3..255); mod_go high exactly 128 single cycles, never two consecutive cycles.
REQ-044 go held high for the whole test, plus an extra go edge mid-test -> exactly one test run, result unchanged.
REQ-045 rst asserted in WAIT during n=65521 -> next cycle ready=1, ops=0, mod_go=0; a following n=91 test yields is_prime=0, ops=4.
REQ-046 Modulo model forcing mod_error=1 on the first op with n=25 -> error=1, is_prime=0, ops=1; the next go with n=7 clears error.

Source files
------------

// File: rtl/prime_check.sv
// Trial-division primality tester driving an external modulo unit.
// Divisors are 2 then odd values while d*d <= n.
module prime_check #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] n,
  output logic             ready,
  output logic             is_prime,
  output logic             error,
  output logic [WIDTH-1:0] ops,
  output logic             mod_go,
  output logic [WIDTH-1:0] mod_a,
  output logic [WIDTH-1:0] mod_b,
  input  logic             mod_ready,
  input  logic             mod_error,
  input  logic [WIDTH-1:0] mod_res
);

  localparam int SW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ISSUE,
    WAIT
  } state_t;

  state_t           state, state_d;
  logic             go_q, go_edge;
  logic             first_q, first_d;
  logic             prime_d, error_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] ops_d;
  logic [WIDTH-1:0] mod_a_d, mod_b_d;
  logic [SW-1:0]    sq_q, sq_d;
  logic [SW-1:0]    n_wide, step;

  assign go_edge = go & ~go_q;
  assign n_wide  = {{WIDTH{1'b0}}, n_q};
  // (d+2)^2 - d^2 = 4d + 4
  assign step    = ({{WIDTH{1'b0}}, d_q} << 2) + SW'(4);

  always_comb begin
    state_d = state;
    first_d = 1'b0;
    prime_d = is_prime;
    error_d = error;
    n_d     = n_q;
    d_d     = d_q;
    sq_d    = sq_q;
    ops_d   = ops;
    mod_a_d = mod_a;
    mod_b_d = mod_b;
    unique case (state)
      IDLE: begin
        if (go_edge) begin
          n_d     = n;
          d_d     = WIDTH'(2);
          sq_d    = SW'(4);
          ops_d   = '0;
          error_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (n_q < WIDTH'(2)) begin
          prime_d = 1'b0;
          state_d = IDLE;
        end else if (sq_q > n_wide) begin
          prime_d = 1'b1;
          state_d = IDLE;
        end else begin
          mod_a_d = n_q;
          mod_b_d = d_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!(&ops)) begin
          ops_d = ops + WIDTH'(1);
        end
        first_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // first cycle may still see the previous op's ready
        if (first_q || !mod_ready) begin
          state_d = WAIT;
        end else if (mod_error) begin
          error_d = 1'b1;
          prime_d = 1'b0;
          state_d = IDLE;
        end else if (mod_res == '0) begin
          prime_d = 1'b0;
          state_d = IDLE;
        end else begin
          if (d_q == WIDTH'(2)) begin
            d_d  = WIDTH'(3);
            sq_d = SW'(9);
          end else begin
            d_d  = d_q + WIDTH'(2);
            sq_d = sq_q + step;
          end
          state_d = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      go_q     <= 1'b0;
      first_q  <= 1'b0;
      ready    <= 1'b1;
      is_prime <= 1'b0;
      error    <= 1'b0;
      ops      <= '0;
      mod_go   <= 1'b0;
      mod_a    <= '0;
      mod_b    <= '0;
      n_q      <= '0;
      d_q      <= '0;
      sq_q     <= '0;
    end else begin
      state    <= state_d;
      go_q     <= go;
      first_q  <= first_d;
      ready    <= (state_d == IDLE);
      is_prime <= prime_d;
      error    <= error_d;
      ops      <= ops_d;
      mod_go   <= (state_d == ISSUE);
      mod_a    <= mod_a_d;
      mod_b    <= mod_b_d;
      n_q      <= n_d;
      d_q      <= d_d;
      sq_q     <= sq_d;
    end
  end

endmodule

// File: tb/tb_prime_check.sv
// Randomized bench for prime_check with a behavioural modulo unit
// and an arithmetic trial-division reference.
module tb_prime_check;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [15:0] n = '0;
  logic        ready, is_prime, error;
  logic [15:0] ops;
  logic        mod_go;
  logic [15:0] mod_a, mod_b;
  logic        mod_ready = 1'b1;
  logic        mod_error = 1'b0;
  logic [15:0] mod_res = '0;

  logic [15:0] ma = '0, mb = '0;
  int          cnt = 0;
  bit          inj_err = 1'b0;

  int  errors = 0;
  int  checks = 0;
  int  pulses = 0;
  int  dbls = 0;
  logic mg_q = 1'b0;
  bit  last_p = 1'b0;

  prime_check #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .go(go), .n(n),
    .ready(ready), .is_prime(is_prime),
    .error(error), .ops(ops),
    .mod_go(mod_go), .mod_a(mod_a), .mod_b(mod_b),
    .mod_ready(mod_ready), .mod_error(mod_error),
    .mod_res(mod_res)
  );

  always #5 clk = ~clk;

  // modulo unit: ready stays high (stale) one cycle after go
  always @(posedge clk) begin
    if (mod_go) begin
      ma  <= mod_a;
      mb  <= mod_b;
      cnt <= $urandom_range(2, 4);
    end else if (cnt > 1) begin
      mod_ready <= 1'b0;
      cnt       <= cnt - 1;
    end else if (cnt == 1) begin
      mod_ready <= 1'b1;
      mod_res   <= ma % mb;
      mod_error <= inj_err;
      cnt       <= 0;
    end
  end

  always @(negedge clk) begin
    if (mod_go) pulses <= pulses + 1;
    if (mod_go && mg_q) dbls <= dbls + 1;
    mg_q <= mod_go;
  end

  task automatic chk(input string tag,
                     input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic void ref_model(
    input  int unsigned nv,
    output bit          p,
    output int          k);
    int unsigned d;
    d = 2;
    k = 0;
    p = 1'b0;
    if (nv < 2) return;
    while (d * d <= nv) begin
      k++;
      if (nv % d == 0) return;
      d = (d == 2) ? 3 : d + 2;
    end
    p = 1'b1;
  endfunction

  task automatic start(input int unsigned nv);
    @(negedge clk);
    n  = 16'(nv);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!ready && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (!ready) chk("timeout", 0, 1);
  endtask

  task automatic run(input int unsigned nv,
                     input string tag,
                     output int cyc);
    bit p;
    int k, p0, d0;
    ref_model(nv, p, k);
    p0 = pulses;
    d0 = dbls;
    start(nv);
    chk({tag, ".busy"}, ready, 0);
    chk({tag, ".hold"}, is_prime, last_p);
    wait_done(cyc);
    chk({tag, ".prime"}, is_prime, p);
    chk({tag, ".ops"}, ops, k);
    chk({tag, ".err"}, error, 0);
    chk({tag, ".pulses"}, pulses - p0, k);
    chk({tag, ".dbl"}, dbls - d0, 0);
    last_p = p;
  endtask

  initial begin
    int cyc, p0, k;
    bit p;
    logic [15:0] smalls [4];
    smalls = '{16'd0, 16'd1, 16'd2, 16'd3};

    repeat (2) @(negedge clk);
    chk("rst.ready", ready, 1);
    chk("rst.prime", is_prime, 0);
    chk("rst.err", error, 0);
    chk("rst.ops", ops, 0);
    chk("rst.mod_go", mod_go, 0);
    chk("rst.mod_a", mod_a, 0);
    chk("rst.mod_b", mod_b, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run(97, "n97", cyc);
    chk("n97.ops5", ops, 5);
    run(91, "n91", cyc);
    run(4, "n4", cyc);
    chk("n4.ops1", ops, 1);
    foreach (smalls[i]) begin
      run(smalls[i], "small", cyc);
      chk("small.lat", cyc <= 2, 1);
    end
    run(65521, "n65521", cyc);
    chk("n65521.ops", ops, 128);

    // go held high, plus an extra edge mid-test
    @(negedge clk);
    n  = 16'd97;
    go = 1'b1;
    p0 = pulses;
    @(negedge clk);
    chk("hold.busy", ready, 0);
    repeat (6) @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    wait_done(cyc);
    chk("hold.prime", is_prime, 1);
    chk("hold.ops", ops, 5);
    repeat (6) @(negedge clk);
    chk("hold.idle", ready, 1);
    chk("hold.pulses", pulses - p0, 5);
    go = 1'b0;
    last_p = 1'b1;

    // reset while waiting on the modulo unit
    start(65521);
    repeat (20) @(negedge clk);
    cyc = 0;
    while (!mod_go && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst.found", mod_go, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.ready", ready, 1);
    chk("midrst.ops", ops, 0);
    chk("midrst.mod_go", mod_go, 0);
    chk("midrst.mod_a", mod_a, 0);
    last_p = 1'b0;
    run(91, "after_rst", cyc);
    chk("after_rst.ops4", ops, 4);

    // go already high as reset releases
    @(negedge clk);
    rst = 1'b1;
    go  = 1'b1;
    n   = 16'd13;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("gorst.busy", ready, 0);
    go = 1'b0;
    wait_done(cyc);
    ref_model(13, p, k);
    chk("gorst.prime", is_prime, p);
    chk("gorst.ops", ops, k);
    last_p = p;

    // modulo error on the first op
    inj_err = 1'b1;
    start(25);
    chk("merr.busy", ready, 0);
    wait_done(cyc);
    chk("merr.err", error, 1);
    chk("merr.prime", is_prime, 0);
    chk("merr.ops", ops, 1);
    inj_err = 1'b0;
    start(7);
    chk("merr.clear", error, 0);
    wait_done(cyc);
    chk("n7.prime", is_prime, 1);
    chk("n7.err", error, 0);
    last_p = 1'b1;

    for (int i = 0; i < 40; i++) begin
      int unsigned nv;
      if ($urandom_range(0, 1) == 0)
        nv = $urandom_range(0, 400);
      else
        nv = $urandom_range(0, 65535);
      run(nv, "rand", cyc);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
